// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
//   Read-side controller for the 16-entry transaction-layer FIFO. Owns the
//   read pointer into the FIFO memory, fetches entries into a registered
//   output stage and presents them downstream over valid/ready. Reports
//   empty / almost-empty / occupancy of the entries still held in memory.
//
// Ports
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-high reset
//   wptr          write pointer (AW+1 bits, MSB = wrap bit), same clock domain
//   mem_rdata     memory read data, combinationally addressed by rptr[AW-1:0]
//   flush         discard all unread entries (including the output stage)
//   rd_ready      downstream accepts rd_data this cycle
//   rptr          read pointer to the memory array (registered)
//   rd_valid      rd_data holds a valid entry (registered)
//   rd_data       output entry (registered)
//   empty         memory holds no unfetched entry
//   almost_empty  fifo_count <= AEMPTY_TH
//   fifo_count    wptr - rptr (entries still in memory, 0..2^AW)
//   xfer_count    accepted transfers, wraps at 2^16
module fifo_read_ctrl #(
  parameter int DW        = 10,
  parameter int AW        = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   wptr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          flush,
  input  logic          rd_ready,
  output logic [AW:0]   rptr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   xfer_count
);

  localparam logic [AW:0] AE_TH  = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic accept;
  logic load;

  // Full-width compare: a full FIFO has equal index bits but differing
  // wrap bits, so it is correctly reported as non-empty.
  assign empty        = (wptr == rptr);
  assign fifo_count   = wptr - rptr;
  assign almost_empty = (fifo_count <= AE_TH);

  assign accept = rd_valid & rd_ready;
  // Refill whenever the output stage is free or being drained this cycle.
  assign load   = !empty & (!rd_valid | rd_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      rptr     <= wptr;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (load) begin
      rd_data  <= mem_rdata;
      rd_valid <= 1'b1;
      rptr     <= rptr + PTR_ONE;
    end else if (accept) begin
      rd_valid <= 1'b0;
    end
  end

  // Counted independently of flush: an accept in a flush cycle still
  // completed a transfer downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  localparam int DW = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   wptr;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic          rd_ready;
  logic [AW:0]   rptr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   fifo_count;
  logic [15:0]   xfer_count;

  logic [DW-1:0] mem [16];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: queue of entries still in memory, one output slot,
  // and a transfer counter.
  logic [DW-1:0] pending [$];
  bit            mvalid;
  logic [DW-1:0] mdata;
  logic [15:0]   mxfer;
  logic [DW-1:0] next_val;

  fifo_read_ctrl #(.DW(DW), .AW(AW), .AEMPTY_TH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wptr         (wptr),
    .mem_rdata    (mem_rdata),
    .flush        (flush),
    .rd_ready     (rd_ready),
    .rptr         (rptr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .xfer_count   (xfer_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[rptr[AW-1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW:0] er;
    er = wptr - (AW+1)'(pending.size());
    chk("rd_valid",     32'(rd_valid),     32'(mvalid));
    chk("rd_data",      32'(rd_data),      32'(mdata));
    chk("rptr",         32'(rptr),         32'(er));
    chk("fifo_count",   32'(fifo_count),   32'(pending.size()));
    chk("empty",        32'(empty),        32'(pending.size() == 0));
    chk("almost_empty", 32'(almost_empty), 32'(pending.size() <= 2));
    chk("xfer_count",   32'(xfer_count),   32'(mxfer));
  endtask

  // One clock: inputs held for the edge, model stepped, then nwr entries are
  // written by the write side just after the edge.
  task automatic cycle(input int nwr, input bit rdy, input bit fl);
    bit acc;
    rd_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
    acc = mvalid && rdy;
    if (acc) mxfer++;
    if (fl) begin
      pending.delete();
      mvalid = 1'b0;
      mdata  = '0;
    end else if (pending.size() > 0 && (!mvalid || rdy)) begin
      mdata  = pending.pop_front();
      mvalid = 1'b1;
    end else if (acc) begin
      mvalid = 1'b0;
    end
    for (int i = 0; i < nwr; i++) begin
      mem[wptr[AW-1:0]] = next_val;
      pending.push_back(next_val);
      next_val = next_val + 1'b1;
      wptr = wptr + 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] first;
    logic [15:0]   base;
    int            written;
    int            cyc;
    int            nwr;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst      = 1'b1;
    wptr     = '0;
    flush    = 1'b0;
    rd_ready = 1'b0;
    mvalid   = 1'b0;
    mdata    = '0;
    mxfer    = '0;
    next_val = 10'h001;

    // Reset / idle
    #12;
    check_all();
    rst = 1'b0;
    #10;
    check_all();

    // Three consecutive writes, downstream always ready
    cycle(1, 1'b1, 1'b0);
    chk("lat_valid_low", 32'(rd_valid), 32'd0);
    cycle(1, 1'b1, 1'b0);
    chk("first_out", 32'(rd_data), 32'h001);
    cycle(1, 1'b1, 1'b0);
    chk("second_out", 32'(rd_data), 32'h002);
    cycle(0, 1'b1, 1'b0);
    chk("third_out", 32'(rd_data), 32'h003);
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);
    chk("seq3_rptr", 32'(rptr), 32'd3);
    chk("seq3_xfer", 32'(xfer_count), 32'd3);

    // Full FIFO, stall, drain
    cycle(16, 1'b0, 1'b0);
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_empty", 32'(empty), 32'd0);
    first = pending[0];
    cycle(0, 1'b0, 1'b0);
    chk("full_load_data", 32'(rd_data), 32'(first));
    chk("full_load_count", 32'(fifo_count), 32'd15);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1'b0, 1'b0);
      chk("stall_data", 32'(rd_data), 32'(first));
    end
    for (int i = 0; i < 18; i++) cycle(0, 1'b1, 1'b0);
    chk("drain_xfer", 32'(xfer_count), 32'd19);

    // Wrap: 40 entries streamed
    base = mxfer;
    for (int i = 0; i < 40; i++) cycle(1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0);
    chk("wrap_xfer", 32'(xfer_count - base), 32'd40);

    // Flush with 5 unread entries and a stalled output stage
    cycle(6, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(fifo_count), 32'd5);
    base = mxfer;
    cycle(0, 1'b0, 1'b1);
    chk("flush_rptr", 32'(rptr), 32'(wptr));
    chk("flush_valid", 32'(rd_valid), 32'd0);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_xfer", 32'(xfer_count), 32'(base));

    // Flush coinciding with an accept, then flush with a same-cycle write
    cycle(3, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0);
    base = mxfer;
    cycle(1, 1'b1, 1'b1);
    chk("flush_acc_xfer", 32'(xfer_count - base), 32'd1);
    chk("flush_wr_count", 32'(fifo_count), 32'd1);
    cycle(0, 1'b0, 1'b0);
    chk("flush_wr_fetch", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 2; i++) cycle(0, 1'b1, 1'b0);

    // Random ready / random writes, 200 entries
    base    = mxfer;
    written = 0;
    cyc     = 0;
    while (16'(mxfer - base) != 16'd200 && cyc < 5000) begin
      nwr = (written < 200 && pending.size() < 16 && $urandom_range(0, 1) == 1) ? 1 : 0;
      cycle(nwr, 1'($urandom_range(0, 1)), 1'b0);
      written += nwr;
      cyc++;
    end
    chk("rand_timeout", 32'(cyc < 5000), 32'd1);
    chk("rand_xfer", 32'(16'(xfer_count - base)), 32'd200);

    // Asynchronous reset mid-transfer
    cycle(3, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    #2;
    rst  = 1'b1;
    wptr = '0;
    pending.delete();
    mvalid = 1'b0;
    mdata  = '0;
    mxfer  = '0;
    #1;
    check_all();
    #3;
    rst = 1'b0;
    cycle(2, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
